// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared types for the UART transmit control unit.
//   tx_state_t : transmit sequencer states (3-bit encoding)
//   tx_sel_t   : line mux select driven to the TX datapath
//   clog2_min1 : counter width helper that never returns 0
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } tx_state_t;

  typedef enum logic [1:0] {
    SEL_IDLE  = 2'b00,
    SEL_START = 2'b01,
    SEL_DATA  = 2'b10,
    SEL_STOP  = 2'b11
  } tx_sel_t;

  // Width needed to hold values 0..v-1; a counter is always at least 1 bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    if (v <= 2) return 1;
    return $clog2(v);
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
// Rollover counter for one serial bit period. Counts 0..PERIOD-1 while
// enabled and wraps to 0 after the terminal count. A clear forces 0 and wins
// over enable.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : force count to 0 at the next edge
//   en_i   : advance the count at the next edge
//   tc_o   : count is at PERIOD-1 (not gated by en_i)
// -----------------------------------------------------------------------------
module tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = clog2_min1(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Full-width compare: the count is kept in 0..PERIOD-1 and never relies on
  // a power-of-two wrap.
  assign tc_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (tc_o) count_d = '0;
      else      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/tcu.sv
// -----------------------------------------------------------------------------
// tcu - UART transmit control unit
// Sequences the TX datapath through LOAD, start bit, DATA_BITS data bits
// (LSB first) and stop bit, then a one-cycle DONE.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset
//   tx_start     : transmit request, sampled every rising edge
//   load_data    : pulse, datapath loads holding register into shift register
//   shift_strobe : pulse at the end of each data bit, datapath shifts right
//   tx_sel       : line mux select (idle/start/data/stop)
//   tx_busy      : state is not IDLE
//   tx_done      : pulse in the DONE cycle after a stop bit completes
//   tx_overrun   : registered pulse, a request was dropped
//
// Host handshake: a request is tx_start=1 at a rising edge; every cycle it is
// high counts as a new request. In IDLE it starts a frame. While busy the
// first request is parked as pending and the host must keep its data stable
// in the holding register until load_data; a request that arrives with one
// already pending is dropped and flagged on tx_overrun in the next cycle.
// In DONE a pending request is consumed (frame restarts at LOAD) and any new
// request at that edge becomes the next pending one.
// -----------------------------------------------------------------------------
module tcu
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  output logic       load_data,
  output logic       shift_strobe,
  output logic [1:0] tx_sel,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun
);

  localparam int unsigned CW = clog2_min1(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  tx_state_t     state_q,    state_d;
  logic [CW-1:0] bit_cnt_q,  bit_cnt_d;
  logic          pending_q,  pending_d;
  logic          overrun_q,  overrun_d;

  logic timer_run;
  logic timer_tc;
  logic bit_end;
  tx_sel_t sel;

  // The timer only runs during the three timed line periods; outside them it
  // is held at 0, so every START/DATA/STOP period begins from a clean count.
  assign timer_run = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign bit_end   = timer_run && timer_tc;

  tx_bit_timer #(
    .PERIOD (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (!timer_run),
    .en_i  (timer_run),
    .tc_o  (timer_tc)
  );

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) state_d = LOAD;
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
          else                       bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) state_d = DONE;
      end
      DONE: begin
        if (pending_q) begin
          state_d   = LOAD;
          // The parked request is consumed; a request at this edge takes
          // its place.
          pending_d = tx_start;
        end else if (tx_start) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests while busy in LOAD..STOP: park one, drop the rest.
    if (tx_start && (state_q != IDLE) && (state_q != DONE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Moore output decode.
  always_comb begin
    sel = SEL_IDLE;
    case (state_q)
      START:   sel = SEL_START;
      DATA:    sel = SEL_DATA;
      STOP:    sel = SEL_STOP;
      default: sel = SEL_IDLE;
    endcase
  end

  assign tx_sel       = sel;
  assign load_data    = (state_q == LOAD);
  assign shift_strobe = (state_q == DATA) && timer_tc;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done      = (state_q == DONE);
  assign tx_overrun   = overrun_q;

endmodule
